// File: rtl/lsu.sv
// Load/store unit: takes one op from execute, issues at most one memory request, returns one writeback.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned load/store instead of aligning the address).
module lsu #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ex_valid,
    output logic         ex_ready,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] write_data,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [4:0]   rd,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata,
    output logic         wb_valid,
    output logic         wb_we,
    output logic [N-1:0] wb_data,
    output logic [4:0]   wb_rd,
    output logic         fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_e;

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [N-1:0] data_q, data_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [4:0]   rd_q, rd_d;
    logic         fault_q, fault_d;

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] low_bits);
        return (low_bits != 3'b000);
    endfunction
`endif

    // State and operand registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_ALU;
            data_q  <= {N{1'b0}};
            wdata_q <= {N{1'b0}};
            rd_q    <= 5'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic; data_q holds the address until a load returns, then the load data.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    data_d  = alu_result;
                    wdata_d = write_data;
                    rd_d    = rd;
                    if (mem_read) begin
                        op_d = OP_LOAD;
                    end else if (mem_write) begin
                        op_d = OP_STORE;
                    end else begin
                        op_d = OP_ALU;
                    end
                    if (mem_read && mem_write) begin
                        fault_d = 1'b1;
                    end else if (mem_read || mem_write) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(alu_result[2:0])) begin
                            fault_d = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
`else
                        state_d = REQ;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = (op_q == OP_LOAD) ? WAIT : DONE;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only, so they are glitch-free and forced by reset.
    assign ex_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && (op_q == OP_STORE);
    assign mem_addr  = mem_req ? {data_q[N-1:3], 3'b000} : {N{1'b0}};
    assign mem_wdata = mem_we ? wdata_q : {N{1'b0}};
    assign wb_valid  = (state_q == DONE);
    assign wb_we     = wb_valid && (op_q != OP_STORE);
    assign wb_data   = wb_we ? data_q : {N{1'b0}};
    assign wb_rd     = wb_valid ? rd_q : 5'd0;
    assign fault     = fault_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter N, default 64, datapath width in bits.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port ex_valid  in  1  execute stage presents an operation.
REQ-005 SHALL have port ex_ready  out  1  lsu accepts an operation this cycle.
REQ-006 SHALL have port alu_result  in  N  ALU output: address (load/store) or result (other).
REQ-007 SHALL have port write_data  in  N  store data.
REQ-008 SHALL have ports mem_read, mem_write  in  1 each  operation kind.
REQ-009 SHALL have port rd  in  5  destination register.
REQ-010 SHALL have ports mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  N  memory request.
REQ-011 SHALL have port mem_gnt  in  1  memory accepts request.
REQ-012 SHALL have ports mem_rvalid  in  1; mem_rdata  in  N  load return.
REQ-013 SHALL have ports wb_valid, wb_we  out  1; wb_data  out  N; wb_rd  out  5  writeback.
REQ-014 SHALL have port fault  out  1  one-cycle pulse, illegal operation dropped.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, DONE; ex_ready=1 only in IDLE.
REQ-016 Accept = ex_valid & ex_ready; on accept SHALL register alu_result, write_data, rd, op kind.
REQ-017 Accept with neither mem_read nor mem_write: IDLE->DONE; next cycle wb_valid=1, wb_we=1, wb_data=registered alu_result.
REQ-018 Accept with mem_read xor mem_write: IDLE->REQ; mem_req=1 from next cycle, mem_addr/mem_wdata/mem_we stable until mem_gnt.
REQ-019 REQ with mem_gnt=1: load ->WAIT, store ->DONE; mem_req deasserts the following cycle.
REQ-020 WAIT SHALL ignore mem_rvalid in the grant cycle; on mem_rvalid=1 capture mem_rdata, ->DONE.
REQ-021 DONE SHALL last exactly one cycle with wb_valid=1 then ->IDLE; store: wb_we=0, wb_data=0.
REQ-022 wb_rd SHALL equal registered rd whenever wb_valid=1; wb_* SHALL be 0 when wb_valid=0.
REQ-023 Accept with mem_read=1 and mem_write=1 SHALL issue no memory request, pulse fault next cycle, stay IDLE.
REQ-024 Minimum latency accept->wb_valid: 1 cycle (non-memory), 2 cycles (store, immediate gnt), 3 cycles (load, gnt then rvalid).
REQ-025 mem_gnt outside REQ and mem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, ex_ready=1, all other outputs 0, regardless of clk.
REQ-027 Reset mid-transaction SHALL abandon it; a later stray mem_rvalid SHALL be ignored.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: load/store with alu_result[2:0]!=0 SHALL issue no request, pulse fault next cycle, stay IDLE.
REQ-029 Macro LSU_MISALIGN_TRAP_EN undefined: mem_addr SHALL be alu_result with bits [2:0] forced to 0; fault only per REQ-023.

Verification
REQ-030 Non-memory: alu_result=0x2A, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x2A, wb_rd=5.
REQ-031 Load addr 0x100, gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF -> mem_req held 3 cycles, wb_data=0xDEADBEEF.
REQ-032 Store addr 0x08 data 0x55, immediate gnt -> mem_we=1, mem_wdata=0x55, wb_valid=1 with wb_we=0 after 2 cycles.
REQ-033 Load addr 0x103 -> macro defined: fault pulse, mem_req never 1; undefined: mem_addr=0x100.
REQ-034 reset=0 while in WAIT, then rvalid=1 -> all outputs 0, wb_valid stays 0, ex_ready=1.
REQ-035 mem_read=mem_write=1 -> fault=1 one cycle, no mem_req, ex_ready stays 1.
